sobel_window_conv: RTL
======================

Name: sobel_window_conv

Overview:
- Streaming 3x3 Sobel convolution engine for the Lab2 convolution datapath.
- Accepts unsigned grayscale pixels in raster order and buffers two lines in internal memories.
- Emits one signed, scaled gradient (Gx or Gy) per interior window position.
- It is the producer side of the existing absolute-value stage: its signed output feeds the 12-bit magnitude block directly.

Parameters:
- WIDTH, 640: pixels per line (>= 3).
- HEIGHT, 480: lines per frame (>= 3).
- DW, 12: pixel width and output width in bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  pixel qualifier; a pixel is accepted on any cycle with in_valid=1.
- in_sof  input  1  start of frame, qualified by in_valid; marks pixel (row 0, col 0).
- in_pix  input  DW  unsigned pixel value.
- sel_gy  input  1  0 selects Gx, 1 selects Gy; sampled together with the accepted pixel.
- out_valid  output  1  one-cycle strobe per result.
- out_grad  output  DW  signed two's-complement gradient.
- frame_done  output  1  one-cycle pulse after the last result of a frame.
- busy  output  1  high while state is ACTIVE.

Behaviour:
- Reset: state goes to IDLE; row and col counters go to 0; out_valid=0, out_grad=0, frame_done=0, busy=0. Line-buffer contents are don't-care.
- No backpressure. in_valid may drop on any cycle; idle cycles do not disturb the window or the counters.
- Two internal line memories, each WIDTH x DW, hold lines row-1 and row-2.
- A 3x3 window of registers shifts left by one column per accepted pixel.
- State machine:
  - IDLE: wait for in_valid=1 with in_sof=1. Pixels that arrive without in_sof are discarded. On the first in_sof pixel, move to ACTIVE with that pixel at (0,0).
  - ACTIVE: each accepted pixel advances col. At col=WIDTH-1, col wraps to 0 and row increments. After pixel (HEIGHT-1, WIDTH-1) is accepted, move to DONE.
  - DONE: stay one cycle, then return to IDLE. Pixels arriving in DONE are discarded unless they carry in_sof, in which case they start a new frame.
- in_sof seen in ACTIVE: abandon the current frame, take this pixel as (0,0), produce no further results for the old frame, and do not pulse frame_done for it.
- Result qualification: the accepted pixel at (r,c) produces a result only when r>=2 and c>=2. That result is centred on (r-1, c-1).
  - Windows never straddle a line boundary.
  - Results per frame = (WIDTH-2)*(HEIGHT-2).
- Arithmetic, with the window indexed [row top..bottom][col left..right]:
  - Gx = (TR + 2*MR + BR) - (TL + 2*ML + BL).
  - Gy = (BL + 2*BM + BR) - (TL + 2*TM + TR).
  - Compute at DW+4 bits signed; no overflow is possible.
  - out_grad = G >>> 3 (arithmetic shift, i.e. floor). For DW=12 the range is -2048..2047, so no saturation is needed.
- Latency: out_valid and out_grad update exactly 2 clocks after the accepting edge, independent of gaps in in_valid.
  - Stage 1: line-buffer read and window shift.
  - Stage 2: arithmetic and output register.
- out_grad holds its last value while out_valid=0.
- frame_done pulses 1 cycle after the final result's out_valid, i.e. 3 clocks after the last pixel is accepted.
- sel_gy travels down the pipeline with its pixel, so changing it mid-frame affects only the results of later pixels.
- rst mid-frame: the pipeline is flushed; any result in flight is not emitted, and frame_done does not pulse.
- Simultaneous events: rst overrides everything. An in_sof pixel accepted in the same cycle as the old frame's stage-2 output still lets that output emit.

Test Plan (WIDTH=4, HEIGHT=4, DW=12):
- Constant frame of 100, sel_gy=0 -> 4 results, all 0; frame_done pulses once, 3 clocks after pixel 16.
- Horizontal ramp pix=col*8 (0, 8, 16, 24 on every row), sel_gy=0 -> 4 results of 8 (64>>>3); repeat with sel_gy=1 -> 4 results of 0.
- Vertical step: rows 0-1 = 0, rows 2-3 = 4095, sel_gy=1 -> 4 results of 2047. Inverted step (rows 0-1 = 4095, rows 2-3 = 0) -> 4 results of -2048 (0x800).
- Ramp frame with in_valid toggling every other cycle -> same 4 values of 8; each out_valid exactly 2 clocks after its qualifying pixel (pixels 11, 12, 15, 16).
- rst asserted after 10 pixels, then a full constant-100 frame -> no output from the partial frame, 4 zeros from the new frame, 1 frame_done.
- in_sof reasserted after 9 pixels of a ramp frame, followed by a full frame -> no frame_done for the aborted frame; the new frame produces 4 correct results and 1 frame_done. Pixels sent without in_sof while in IDLE produce no output.

Source files
------------

// File: rtl/sobel_window_conv_if.sv
// Pixel-in / gradient-out bundle for the Sobel window engine.
// No latency of its own; pure wiring between producer and engine.
// No backpressure signals: the engine always accepts and never stalls.
interface sobel_window_conv_if #(
  parameter int DW = 12
);
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_pix;
  logic          sel_gy;
  logic          out_valid;
  logic [DW-1:0] out_grad;
  logic          frame_done;
  logic          busy;

  // Pixel source side (testbench or upstream stage)
  modport master (
    output in_valid, in_sof, in_pix, sel_gy,
    input  out_valid, out_grad, frame_done, busy
  );

  // Convolution engine side
  modport slave (
    input  in_valid, in_sof, in_pix, sel_gy,
    output out_valid, out_grad, frame_done, busy
  );
endinterface

// File: rtl/sobel_window_conv.sv
// Streaming 3x3 Sobel (Gx or Gy) over raster pixels, two line memories, output scaled by 1/8.
// Latency: result 2 clocks after the accepting edge of pixel (r>=2,c>=2); frame_done 1 clock later.
// No backpressure: every in_valid cycle is consumed; idle cycles leave window and counters untouched.
module sobel_window_conv #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DW     = 12
) (
  input  logic              clk,
  input  logic              rst,
  sobel_window_conv_if.slave bus
);
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Accept stage: captured pixel, line-memory read data and control tags
  logic          p_vld_q, p_vld_d;
  logic          p_qual_q, p_qual_d;
  logic          p_last_q, p_last_d;
  logic          p_gy_q, p_gy_d;
  logic [DW-1:0] p_pix_q, p_pix_d;
  logic [DW-1:0] rd1_q, rd1_d;
  logic [DW-1:0] rd2_q, rd2_d;

  // Window stage: [row top..bottom][col left..right]
  logic [2:0][2:0][DW-1:0] win_q, win_d;
  logic          s1_vld_q, s1_vld_d;
  logic          s1_last_q, s1_last_d;
  logic          s1_gy_q, s1_gy_d;

  // Output stage
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_grad_q, out_grad_d;
  logic          s2_last_q, s2_last_d;
  logic          frame_done_q, frame_done_d;

  // Line memories: lb1 holds row-1, lb2 holds row-2, indexed by column
  logic [DW-1:0] lb1_mem [WIDTH];
  logic [DW-1:0] lb2_mem [WIDTH];

  logic          take, start, abandon, at_eol, at_last;
  logic [CW-1:0] pos_c;
  logic [RW-1:0] pos_r;
  logic signed [DW+3:0] tl, tm, tr, ml, mr, bl, bm, br, grad;

  // Frame FSM and raster position: an sof pixel always restarts at (0,0)
  always_comb begin
    start   = bus.in_valid && bus.in_sof;
    take    = bus.in_valid && (bus.in_sof || (state_q == ACTIVE));
    abandon = start && (state_q == ACTIVE);
    pos_r   = start ? '0 : row_q;
    pos_c   = start ? '0 : col_q;
    at_eol  = (pos_c == CW'(WIDTH - 1));
    at_last = at_eol && (pos_r == RW'(HEIGHT - 1));
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE:    if (start) state_d = ACTIVE;
      ACTIVE:  state_d = ACTIVE;
      DONE:    state_d = start ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
    if (take) begin
      if (at_last) begin
        state_d = DONE;
        row_d   = '0;
        col_d   = '0;
      end else if (at_eol) begin
        row_d = pos_r + RW'(1);
        col_d = '0;
      end else begin
        row_d = pos_r;
        col_d = pos_c + CW'(1);
      end
    end
  end

  // Pipeline next-state: accept/read, window shift, tag propagation
  always_comb begin
    p_vld_d  = take;
    p_qual_d = take && (pos_r >= RW'(2)) && (pos_c >= CW'(2));
    p_last_d = take && at_last;
    p_gy_d   = take ? bus.sel_gy : p_gy_q;
    p_pix_d  = take ? bus.in_pix : p_pix_q;
    rd1_d    = take ? lb1_mem[pos_c] : rd1_q;
    rd2_d    = take ? lb2_mem[pos_c] : rd2_q;
    win_d    = win_q;
    if (p_vld_q) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = rd2_q;
      win_d[1][2] = rd1_q;
      win_d[2][2] = p_pix_q;
    end
    // A restart drops the old frame's result still in the accept stage
    s1_vld_d     = p_qual_q && !abandon;
    s1_last_d    = p_last_q && !abandon;
    s1_gy_d      = p_gy_q;
    out_valid_d  = s1_vld_q;
    out_grad_d   = s1_vld_q ? DW'(grad >>> 3) : out_grad_q;
    s2_last_d    = s1_last_q;
    frame_done_d = s2_last_q;
  end

  // Sobel kernel on the current window; DW+4 signed bits cannot overflow
  always_comb begin
    tl = signed'({4'b0, win_q[0][0]});
    tm = signed'({4'b0, win_q[0][1]});
    tr = signed'({4'b0, win_q[0][2]});
    ml = signed'({4'b0, win_q[1][0]});
    mr = signed'({4'b0, win_q[1][2]});
    bl = signed'({4'b0, win_q[2][0]});
    bm = signed'({4'b0, win_q[2][1]});
    br = signed'({4'b0, win_q[2][2]});
    if (s1_gy_q) grad = (bl + bm + bm + br) - (tl + tm + tm + tr);
    else         grad = (tr + mr + mr + br) - (tl + ml + ml + bl);
  end

  // State and pipeline registers; reset flushes anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      p_vld_q      <= 1'b0;
      p_qual_q     <= 1'b0;
      p_last_q     <= 1'b0;
      p_gy_q       <= 1'b0;
      p_pix_q      <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      win_q        <= '0;
      s1_vld_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_gy_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_grad_q   <= '0;
      s2_last_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      p_vld_q      <= p_vld_d;
      p_qual_q     <= p_qual_d;
      p_last_q     <= p_last_d;
      p_gy_q       <= p_gy_d;
      p_pix_q      <= p_pix_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      win_q        <= win_d;
      s1_vld_q     <= s1_vld_d;
      s1_last_q    <= s1_last_d;
      s1_gy_q      <= s1_gy_d;
      out_valid_q  <= out_valid_d;
      out_grad_q   <= out_grad_d;
      s2_last_q    <= s2_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line memories age one row per accepted pixel (read-before-write)
  always_ff @(posedge clk) begin
    if (take) begin
      lb2_mem[pos_c] <= lb1_mem[pos_c];
      lb1_mem[pos_c] <= bus.in_pix;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_grad   = out_grad_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q == ACTIVE);
endmodule
